mux_arb_reg: RTL

//  Parametrised N:1 datapath selector with valid/ready handshake and a registered output.

---
 rtl/mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mux_arb_reg.sv | 72 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 arbitrated, registered selector.
package mux_pkg;

  typedef logic mode_t;

  localparam mode_t MODE_DIRECT = 1'b0;
  localparam mode_t MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last served channel.
module rr_arbiter #(
  parameter  int unsigned N     = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [SEL_W-1:0] gnt_c,
  output logic             gnt_vld_c,
  output logic [SEL_W-1:0] rr_ptr
);

  int idx;

  // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    gnt_c     = '0;
    gnt_vld_c = |req;
    idx       = 0;
    for (int off = int'(N); off >= 1; off--) begin
      idx = (int'(rr_ptr) + off) % int'(N);
      if (req[idx]) gnt_c = SEL_W'(idx);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      rr_ptr <= SEL_W'(N - 1);
    else if (advance) rr_ptr <= gnt_c;
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N:1 datapath selector with direct-key or round-robin grant and a registered,
// valid/ready output stage that can load on the same edge it drains.
module mux_arb_reg
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned N     = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  mode_t              mode,
  input  logic [SEL_W-1:0]   key,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] rr_gnt_c;
  logic             rr_vld_c;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] gnt_c;
  logic             gnt_vld_c;
  logic             load_en_c;
  logic             accept_c;
  logic [WIDTH-1:0] sel_data_c;

  rr_arbiter #(.N(N)) u_arb (
    .clock     (clock),
    .resetn    (resetn),
    .req       (in_valid),
    .advance   (accept_c && (mode == MODE_RR)),
    .gnt_c     (rr_gnt_c),
    .gnt_vld_c (rr_vld_c),
    .rr_ptr    (rr_ptr)
  );

  // Grant selection; an out-of-range key (N not a power of 2) never grants.
  always_comb begin
    load_en_c = !out_valid || out_ready;
    if (mode == MODE_RR) begin
      gnt_c     = rr_gnt_c;
      gnt_vld_c = rr_vld_c;
    end else begin
      gnt_c     = key;
      gnt_vld_c = (32'(key) < N) && in_valid[key];
    end
    accept_c   = load_en_c && gnt_vld_c && resetn;
    in_ready   = '0;
    if (accept_c) in_ready[gnt_c] = 1'b1;
    sel_data_c = in_data[32'(gnt_c)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_c;
      out_src   <= gnt_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
